// File: rtl/pipelined_reg_file_sb_pkg.sv
// pipelined_reg_file_sb_pkg: default widths and the popcount helper for the register file scoreboard
package pipelined_reg_file_sb_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int MAX_DEPTH = 256;
  function automatic logic [31:0] popcount(input logic [MAX_DEPTH-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) n = n + 32'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/pipelined_reg_file_sb_reg_scoreboard.sv
// reg_scoreboard: per-register pending bits with registered count and double-issue error
// ports: clk/rst_n, iss_en/iss_addr set a bit, wr_en/wr_addr clear a bit (set wins),
//        pending vector, pend_count (registered popcount), iss_err (registered pulse)
module reg_scoreboard
  import pipelined_reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  output logic [2**ADDR_W-1:0]  pending,
  output logic [ADDR_W:0]       pend_count,
  output logic                  iss_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DEPTH-1:0] nxt;
  logic [MAX_DEPTH-1:0] ext;
  always_comb begin
    nxt = pending;
    if (wr_en) nxt[wr_addr] = 1'b0;
    if (iss_en) nxt[iss_addr] = 1'b1;
    ext = '0;
    ext[DEPTH-1:0] = nxt;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
      pend_count <= '0;
      iss_err <= 1'b0;
    end else begin
      pending <= nxt;
      pend_count <= (ADDR_W+1)'(popcount(ext));
      iss_err <= iss_en && pending[iss_addr] && !(wr_en && wr_addr == iss_addr);
    end
  end
endmodule

// File: rtl/pipelined_reg_file_sb.sv
// pipelined_reg_file_sb: 2-read/1-write register file with write bypass and issue scoreboard
// ports: Clk, Reset (sync, active-low), Rd_Addr1/2 -> Rd_Data1/2 (combinational),
//        Wr_En/Wr_Addr/Wr_Data writeback, Iss_En/Iss_Addr issue, Hazard1/2, Stall,
//        Pend_Count, Iss_Err
module pipelined_reg_file_sb
  import pipelined_reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter bit ZERO_R0 = 1'b0,
  parameter bit BYPASS = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Rd_Addr1,
  input  logic [ADDR_W-1:0] Rd_Addr2,
  output logic [DATA_W-1:0] Rd_Data1,
  output logic [DATA_W-1:0] Rd_Data2,
  input  logic              Wr_En,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Iss_En,
  input  logic [ADDR_W-1:0] Iss_Addr,
  output logic              Hazard1,
  output logic              Hazard2,
  output logic              Stall,
  output logic [ADDR_W:0]   Pend_Count,
  output logic              Iss_Err
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic wr_ok, iss_ok, fwd1, fwd2;
  // with ZERO_R0, traffic to r0 is dropped before it reaches data, bypass or scoreboard
  assign wr_ok = Wr_En && !(ZERO_R0 && Wr_Addr == '0);
  assign iss_ok = Iss_En && !(ZERO_R0 && Iss_Addr == '0);
  assign fwd1 = BYPASS && wr_ok && Wr_Addr == Rd_Addr1;
  assign fwd2 = BYPASS && wr_ok && Wr_Addr == Rd_Addr2;
  always_comb begin
    Rd_Data1 = (ZERO_R0 && Rd_Addr1 == '0) ? '0 : fwd1 ? Wr_Data : regs[Rd_Addr1];
    Rd_Data2 = (ZERO_R0 && Rd_Addr2 == '0) ? '0 : fwd2 ? Wr_Data : regs[Rd_Addr2];
    Hazard1 = pending[Rd_Addr1] && !fwd1;
    Hazard2 = pending[Rd_Addr2] && !fwd2;
    Stall = Hazard1 || Hazard2;
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      regs[Wr_Addr] <= Wr_Data;
    end
  end
  reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk(Clk),
    .rst_n(Reset),
    .iss_en(iss_ok),
    .iss_addr(Iss_Addr),
    .wr_en(wr_ok),
    .wr_addr(Wr_Addr),
    .pending(pending),
    .pend_count(Pend_Count),
    .iss_err(Iss_Err)
  );
endmodule

// File: tb/tb_pipelined_reg_file_sb.sv
// tb_pipelined_reg_file_sb: directed vector and sequence checks of the scoreboarded register file
module tb_pipelined_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] ra1, ra2, wa, ia;
  logic [7:0] wd;
  logic we, ie;
  logic [7:0] d1, d2, z1, z2;
  logic h1, h2, st, ierr, zh1, zh2, zst, zierr;
  logic [3:0] pc, zpc;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipelined_reg_file_sb dut (
    .Clk(clk), .Reset(rst), .Rd_Addr1(ra1), .Rd_Addr2(ra2), .Rd_Data1(d1), .Rd_Data2(d2),
    .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Iss_En(ie), .Iss_Addr(ia),
    .Hazard1(h1), .Hazard2(h2), .Stall(st), .Pend_Count(pc), .Iss_Err(ierr)
  );

  pipelined_reg_file_sb #(.ZERO_R0(1'b1)) dut_z (
    .Clk(clk), .Reset(rst), .Rd_Addr1(ra1), .Rd_Addr2(ra2), .Rd_Data1(z1), .Rd_Data2(z2),
    .Wr_En(we), .Wr_Addr(wa), .Wr_Data(wd), .Iss_En(ie), .Iss_Addr(ia),
    .Hazard1(zh1), .Hazard2(zh2), .Stall(zst), .Pend_Count(zpc), .Iss_Err(zierr)
  );

  typedef struct {
    logic we; logic [2:0] wa; logic [7:0] wd;
    logic [2:0] ra1; logic [2:0] ra2;
    logic [7:0] e1; logic [7:0] e2; logic est;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; ie = 1'b0;
  endtask

  initial begin
    ra1 = '0; ra2 = '0; wa = '0; ia = '0; wd = '0; we = 1'b0; ie = 1'b0;
    vecs[0] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'h00, 8'h01, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 8'h02, 8'h03, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd5, 8'h04, 8'h05, 1'b0};
    vecs[3] = '{1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 8'h06, 8'h07, 1'b0};
    vecs[4] = '{1'b1, 3'd5, 8'hA5, 3'd5, 3'd4, 8'hA5, 8'h04, 1'b0};
    vecs[5] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 8'hA5, 8'hA5, 1'b0};
    vecs[6] = '{1'b1, 3'd7, 8'h3C, 3'd6, 3'd7, 8'h06, 8'h3C, 1'b0};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd5, 8'h3C, 8'hA5, 1'b0};
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("reset_pend_count", 32'(pc), 0);
    chk("reset_iss_err", 32'(ierr), 0);
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), 32'(d1), 32'(vecs[i].e1));
      chk($sformatf("vec%0d_rd2", i), 32'(d2), 32'(vecs[i].e2));
      chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].est));
      tick();
    end
    idle();
    // issue 3, read it back as a hazard, then resolve it by writeback with bypass
    ie = 1'b1; ia = 3'd3; tick(); idle();
    ra1 = 3'd3; ra2 = 3'd1; #1;
    chk("iss3_hazard1", 32'(h1), 1);
    chk("iss3_hazard2", 32'(h2), 0);
    chk("iss3_stall", 32'(st), 1);
    chk("iss3_pend_count", 32'(pc), 1);
    we = 1'b1; wa = 3'd3; wd = 8'h33; #1;
    chk("wr3_hazard1", 32'(h1), 0);
    chk("wr3_stall", 32'(st), 0);
    chk("wr3_bypass", 32'(d1), 32'h33);
    tick(); idle(); #1;
    chk("wr3_pend_count", 32'(pc), 0);
    chk("wr3_rd1", 32'(d1), 32'h33);
    // simultaneous issue and write: set wins, no error; then double issue
    ie = 1'b1; ia = 3'd4; we = 1'b1; wa = 3'd4; wd = 8'h44; tick(); idle();
    ra1 = 3'd4; #1;
    chk("iw4_pend_count", 32'(pc), 1);
    chk("iw4_iss_err", 32'(ierr), 0);
    chk("iw4_hazard1", 32'(h1), 1);
    chk("iw4_rd1", 32'(d1), 32'h44);
    ie = 1'b1; ia = 3'd4; tick(); idle(); #1;
    chk("dbl4_iss_err", 32'(ierr), 1);
    chk("dbl4_pend_count", 32'(pc), 1);
    tick();
    chk("dbl4_iss_err_clear", 32'(ierr), 0);
    we = 1'b1; wa = 3'd4; wd = 8'h45; tick(); idle(); #1;
    chk("clr4_pend_count", 32'(pc), 0);
    // r0 traffic: ZERO_R0 instance ignores it, default instance honours it
    we = 1'b1; wa = 3'd0; wd = 8'hFF; ie = 1'b1; ia = 3'd0; ra1 = 3'd0; ra2 = 3'd0; #1;
    chk("z_bypass_rd1", 32'(z1), 0);
    chk("nz_bypass_rd1", 32'(d1), 32'hFF);
    tick(); idle(); #1;
    chk("z_rd1", 32'(z1), 0);
    chk("z_rd2", 32'(z2), 0);
    chk("z_hazard1", 32'(zh1), 0);
    chk("z_stall", 32'(zst), 0);
    chk("z_pend_count", 32'(zpc), 0);
    chk("nz_pend_count", 32'(pc), 1);
    chk("nz_rd1", 32'(d1), 32'hFF);
    // pending work abandoned by reset; simultaneous write and issue discarded
    ie = 1'b1; ia = 3'd2; tick();
    ia = 3'd6; tick(); idle(); #1;
    chk("pre_rst_pend_count", 32'(pc), 3);
    chk("pre_rst_z_pend_count", 32'(zpc), 2);
    chk("pre_rst_z_iss_err", 32'(zierr), 0);
    rst = 1'b0; we = 1'b1; wa = 3'd6; wd = 8'h11; ie = 1'b1; ia = 3'd5;
    tick(); rst = 1'b1; idle();
    ra1 = 3'd6; ra2 = 3'd2; #1;
    chk("rst_pend_count", 32'(pc), 0);
    chk("rst_z_pend_count", 32'(zpc), 0);
    chk("rst_reg6", 32'(d1), 6);
    chk("rst_reg2", 32'(d2), 2);
    chk("rst_stall", 32'(st), 0);
    chk("rst_iss_err", 32'(ierr), 0);
    ra1 = 3'd5; ra2 = 3'd0; #1;
    chk("rst_reg5", 32'(d1), 5);
    chk("rst_reg0", 32'(d2), 0);
    chk("rst_hazard1", 32'(h1), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_reg_file_sb.md
PIPELINED_REG_FILE_SB -- requirements
Module: pipelined_reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, register data width in bits (1..32).
REQ-002 The block SHALL have parameter ADDR_W, default 3, register address width; depth = 2^ADDR_W.
REQ-003 The block SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads 0 and ignores writes and issues.
REQ-004 The block SHALL have parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to the read ports.
REQ-005 The block SHALL have port Clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port Reset, input, 1; reset Reset, synchronous, active-low.
REQ-007 The block SHALL have ports Rd_Addr1 and Rd_Addr2, input, ADDR_W, read addresses.
REQ-008 The block SHALL have ports Rd_Data1 and Rd_Data2, output, DATA_W, read data.
REQ-009 The block SHALL have ports Wr_En (input, 1), Wr_Addr (input, ADDR_W) and Wr_Data (input, DATA_W) forming the writeback port.
REQ-010 The block SHALL have ports Iss_En (input, 1) and Iss_Addr (input, ADDR_W), the issue port marking a destination register pending.
REQ-011 The block SHALL have ports Hazard1 and Hazard2 (output, 1), Stall (output, 1), Pend_Count (output, ADDR_W+1) and Iss_Err (output, 1).

Function
REQ-012 Reads SHALL be combinational: Rd_DataN = reg[Rd_AddrN], zero-latency.
REQ-013 A write SHALL update reg[Wr_Addr] at the rising edge when Reset=1 and Wr_En=1.
REQ-014 With BYPASS=1, Wr_En=1 and Wr_Addr=Rd_AddrN (and the write not suppressed), Rd_DataN SHALL equal Wr_Data in the same cycle.
REQ-015 With ZERO_R0=1, a read of address 0 SHALL return 0, and writes and issues to address 0 SHALL be ignored, including for bypass, scoreboard and Pend_Count.
REQ-016 The scoreboard SHALL hold one pending bit per register; Iss_En sets pending[Iss_Addr] at the edge.
REQ-017 Wr_En SHALL clear pending[Wr_Addr] at the edge.
REQ-018 When Iss_En and Wr_En target the same address in the same cycle, the set SHALL win and the bit remains 1.
REQ-019 HazardN SHALL equal pending[Rd_AddrN], except that it is 0 when BYPASS=1 and a same-cycle write to that address is forwarded.
REQ-020 Stall SHALL equal Hazard1 OR Hazard2, combinationally.
REQ-021 Pend_Count SHALL be a registered population count of the pending bits, updated at each edge and consistent with the next-state pending bits.
REQ-022 Iss_Err SHALL be registered and pulse high for one cycle after an issue to an already-pending register that is not being cleared in the same cycle; the pending bit stays 1.
REQ-023 A write to a non-pending register SHALL still update the data and SHALL leave the scoreboard unchanged.

Reset
REQ-024 When Reset=0 at an edge, reg[i] SHALL be loaded with i truncated to DATA_W bits (reg[0]=0).
REQ-025 When Reset=0 at an edge, all pending bits, Pend_Count and Iss_Err SHALL be cleared.
REQ-026 Reset SHALL take priority over a simultaneous write or issue, which is discarded.
REQ-027 Reset asserted mid-operation SHALL abandon all pending state with no residue after the edge.

Structure
REQ-028 A shared package SHALL hold the default widths and a popcount function for Pend_Count.
REQ-029 The scoreboard SHALL be a sub-module reg_scoreboard, with the data array and bypass kept in the top level.

Verification
REQ-030 The bench SHALL cover reset then read of all 8 addresses, expecting Rd_Data = 0..7 for DATA_W=8 and ADDR_W=3.
REQ-031 The bench SHALL cover Wr_En=1, Wr_Addr=5, Wr_Data=8'hA5 with Rd_Addr1=5 in the same cycle, expecting Rd_Data1=A5 immediately (BYPASS=1) and A5 on later reads.
REQ-032 The bench SHALL cover Iss 3, then read 3 next cycle, expecting Hazard1=1, Stall=1 and Pend_Count=1; then a write to 3 with the read, expecting Hazard1=0 that cycle and Pend_Count=0 after.
REQ-033 The bench SHALL cover Iss 4 and Wr 4 in the same cycle, expecting pending[4]=1, Pend_Count=1 and Iss_Err=0; then Iss 4 again, expecting Iss_Err=1 for one cycle.
REQ-034 The bench SHALL cover ZERO_R0=1 with write 8'hFF to 0 and issue 0, expecting Rd_Data=0, Hazard=0 and Pend_Count=0.
REQ-035 The bench SHALL cover issue to 2 and 6, then Reset=0 together with Wr 6 = 8'h11, expecting Pend_Count=0, reg6=6 and reg2=2.
